mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 32-bit data / 16-bit address memory.
- Port 0 is the CPU fetch/load/store path (MAR / MBR_W / MBR_R / write). Port 1 is a secondary master (loader/debug/DMA).
- Serialises accesses with a req/ack handshake and drives the memory's address, write-data and write-enable.
- Returns read data to the requester that issued the read.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: both requester ports, the memory port and status.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16
);
  logic                 req0;
  logic                 write0;
  logic [BITS_ADDR-1:0] addr0;
  logic [BITS_DATA-1:0] wdata0;
  logic                 ack0;
  logic [BITS_DATA-1:0] rdata0;

  logic                 req1;
  logic                 write1;
  logic [BITS_ADDR-1:0] addr1;
  logic [BITS_DATA-1:0] wdata1;
  logic                 ack1;
  logic [BITS_DATA-1:0] rdata1;

  logic [BITS_ADDR-1:0] mem_addr;
  logic [BITS_DATA-1:0] mem_wdata;
  logic                 mem_write;
  logic [BITS_DATA-1:0] mem_rdata;

  logic                 busy;
  logic                 gnt_id;

  modport slave (
    input  req0, write0, addr0, wdata0,
    input  req1, write1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_addr, mem_wdata, mem_write,
    output busy, gnt_id
  );

  modport master (
    output req0, write0, addr0, wdata0,
    output req1, write1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_addr, mem_wdata, mem_write,
    input  busy, gnt_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the single-port memory: IDLE -> ACCESS -> RESP.
// Define ARB_FIXED_PRIORITY_EN for fixed port-0 priority instead of round-robin.
module mem_port_arbiter #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16
) (
  input  logic            clk,
  input  logic            reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state;
  logic                 ack0R;
  logic                 ack1R;
  logic [BITS_DATA-1:0] rdata0R;
  logic [BITS_DATA-1:0] rdata1R;
  logic [BITS_ADDR-1:0] memAddrR;
  logic [BITS_DATA-1:0] memWdataR;
  logic                 memWriteR;
  logic                 busyR;
  logic                 gntIdR;
  logic                 isWrite;
`ifndef ARB_FIXED_PRIORITY_EN
  logic                 rrPtr;
`endif

  logic elig0;
  logic elig1;
  logic anyElig;
  logic pickPort;

  // A port whose ack is high this cycle is skipped, so a requester that drops
  // req on ack is never serviced a second time.
  always_comb begin
    elig0   = bus.req0 & ~ack0R;
    elig1   = bus.req1 & ~ack1R;
    anyElig = elig0 | elig1;
`ifdef ARB_FIXED_PRIORITY_EN
    pickPort = ~elig0;
`else
    pickPort = (elig0 & elig1) ? rrPtr : elig1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ack0R     <= 1'b0;
      ack1R     <= 1'b0;
      rdata0R   <= '0;
      rdata1R   <= '0;
      memAddrR  <= '0;
      memWdataR <= '0;
      memWriteR <= 1'b0;
      busyR     <= 1'b0;
      gntIdR    <= 1'b0;
      isWrite   <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      rrPtr     <= 1'b0;
`endif
    end else begin
      ack0R <= 1'b0;
      ack1R <= 1'b0;
      case (state)
        IDLE: begin
          if (anyElig) begin
            if (pickPort) begin
              memAddrR  <= bus.addr1;
              memWdataR <= bus.wdata1;
              memWriteR <= bus.write1;
              isWrite   <= bus.write1;
            end else begin
              memAddrR  <= bus.addr0;
              memWdataR <= bus.wdata0;
              memWriteR <= bus.write0;
              isWrite   <= bus.write0;
            end
            gntIdR <= pickPort;
            busyR  <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          memWriteR <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          // mem_addr is still held here, so mem_rdata belongs to this access.
          if (gntIdR) begin
            if (!isWrite) rdata1R <= bus.mem_rdata;
            ack1R <= 1'b1;
          end else begin
            if (!isWrite) rdata0R <= bus.mem_rdata;
            ack0R <= 1'b1;
          end
          busyR <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
          rrPtr <= ~gntIdR;
`endif
          state <= IDLE;
        end
        default: begin
          memWriteR <= 1'b0;
          busyR     <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0      = ack0R;
  assign bus.ack1      = ack1R;
  assign bus.rdata0    = rdata0R;
  assign bus.rdata1    = rdata1R;
  assign bus.mem_addr  = memAddrR;
  assign bus.mem_wdata = memWdataR;
  assign bus.mem_write = memWriteR;
  assign bus.busy      = busyR;
  assign bus.gnt_id    = gntIdR;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default round-robin build)
// with a behavioural single-port memory attached to the memory side.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.BITS_DATA(32), .BITS_ADDR(16)) bus ();

  mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on clock edge; bd* is a preload path.
  logic [31:0] mem [0:65535];
  logic        bdWe;
  logic [15:0] bdAddr;
  logic [31:0] bdData;

  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (bdWe)     mem[bdAddr]       <= bdData;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int checks = 0;
  int passes = 0;
  int bothAck = 0;
  logic [15:0] wAddr;
  logic [31:0] wData;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bdWrite(input logic [15:0] a, input logic [31:0] d);
    bdWe = 1'b1; bdAddr = a; bdData = d;
    tick();
    bdWe = 1'b0;
  endtask

  // Raises one request, waits (bounded) for its ack, then drops req on the ack.
  task automatic issue(input bit port, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, output int lat, output int wcyc);
    if (port == 1'b0) begin
      bus.req0 = 1'b1; bus.write0 = wr; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.write1 = wr; bus.addr1 = a; bus.wdata1 = d;
    end
    lat  = 0;
    wcyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (bus.mem_write) begin
        wcyc++;
        wAddr = bus.mem_addr;
        wData = bus.mem_wdata;
      end
      if (bus.ack0 && bus.ack1) bothAck++;
      if ((port == 1'b0 && bus.ack0) || (port == 1'b1 && bus.ack1)) break;
    end
    if (port == 1'b0) bus.req0 = 1'b0;
    else              bus.req1 = 1'b0;
  endtask

  int lat;
  int wcyc;
  int busyCnt;
  int writeCnt;
  int ng;
  int a0Cnt, a1Cnt, a0First, a0Last, a1First, a1Last;
  logic [3:0] gseq;
  logic prevBusy;

  initial begin
    bdWe = 1'b0; bdAddr = '0; bdData = '0;
    bus.req0 = 1'b1; bus.write0 = 1'b0; bus.addr0 = 16'h0001; bus.wdata0 = '0;
    bus.req1 = 1'b1; bus.write1 = 1'b0; bus.addr1 = 16'h0002; bus.wdata1 = '0;
    reset = 1'b1;

    // 1: reset with both requests held
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ctrl", 64'({bus.ack0, bus.ack1, bus.busy, bus.mem_write, bus.gnt_id}), 64'(0));
      check("rst_bus", 64'({bus.mem_addr, bus.mem_wdata}), 64'(0));
      check("rst_rdata", 64'({bus.rdata0, bus.rdata1}), 64'(0));
    end
    reset = 1'b0;
    tick();
    check("first_gnt", 64'(bus.gnt_id), 64'(0));
    check("first_busy", 64'(bus.busy), 64'(1));
    check("first_addr", 64'(bus.mem_addr), 64'h0001);
    bus.req1 = 1'b0;
    tick();
    tick();
    check("first_ack", 64'({bus.ack0, bus.ack1}), 64'(2'b10));
    bus.req0 = 1'b0;
    tick();
    check("first_done", 64'({bus.ack0, bus.busy}), 64'(0));

    // 2: port 0 read
    bdWrite(16'h0010, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 16'h0010, 32'h0, lat, wcyc);
    check("rd_lat", 64'(lat), 64'(3));
    check("rd_nowrite", 64'(wcyc), 64'(0));
    check("rd_rdata0", 64'(bus.rdata0), 64'hDEADBEEF);
    check("rd_rdata1", 64'(bus.rdata1), 64'(0));
    tick();
    check("rd_ackpulse", 64'({bus.ack0, bus.ack1, bus.busy}), 64'(0));

    // 3: port 1 write, port 0 reads it back, port 1 reads it back
    issue(1'b1, 1'b1, 16'h0020, 32'h12345678, lat, wcyc);
    check("wr_lat", 64'(lat), 64'(3));
    check("wr_cycles", 64'(wcyc), 64'(1));
    check("wr_addr", 64'(wAddr), 64'h0020);
    check("wr_data", 64'(wData), 64'h12345678);
    check("wr_rdata1_kept", 64'(bus.rdata1), 64'(0));
    issue(1'b0, 1'b0, 16'h0020, 32'h0, lat, wcyc);
    check("rb_rdata0", 64'(bus.rdata0), 64'h12345678);
    issue(1'b1, 1'b0, 16'h0020, 32'h0, lat, wcyc);
    check("rb_rdata1", 64'(bus.rdata1), 64'h12345678);
    tick();
    check("rb_idle", 64'({bus.ack0, bus.ack1, bus.busy}), 64'(0));

    // 4: both requesters continuously active
    bdWrite(16'h0001, 32'h11111111);
    bdWrite(16'h0002, 32'h22222222);
    bus.req0 = 1'b1; bus.write0 = 1'b0; bus.addr0 = 16'h0001;
    bus.req1 = 1'b1; bus.write1 = 1'b0; bus.addr1 = 16'h0002;
    ng = 0; gseq = '0; prevBusy = bus.busy; bothAck = 0;
    a0Cnt = 0; a1Cnt = 0; a0First = 0; a0Last = 0; a1First = 0; a1Last = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.busy && !prevBusy && ng < 4) begin
        gseq[ng] = bus.gnt_id;
        ng++;
      end
      prevBusy = bus.busy;
      if (bus.ack0 && bus.ack1) bothAck++;
      if (bus.ack0) begin
        if (a0Cnt == 0) a0First = c;
        a0Last = c;
        a0Cnt++;
      end
      if (bus.ack1) begin
        if (a1Cnt == 0) a1First = c;
        a1Last = c;
        a1Cnt++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("rr_ngrants", 64'(ng), 64'(4));
    check("rr_gseq", 64'(gseq), 64'(4'b1010));
    check("rr_ack0_cnt", 64'(a0Cnt), 64'(2));
    check("rr_ack1_cnt", 64'(a1Cnt), 64'(2));
    check("rr_ack0_cyc", 64'({a0First[7:0], a0Last[7:0]}), 64'({8'd3, 8'd9}));
    check("rr_ack1_cyc", 64'({a1First[7:0], a1Last[7:0]}), 64'({8'd6, 8'd12}));
    check("rr_bothack", 64'(bothAck), 64'(0));
    check("rr_rdata", 64'({bus.rdata0, bus.rdata1}), {32'h11111111, 32'h22222222});
    tick();
    check("rr_idle", 64'(bus.busy), 64'(0));

    // 5: reset during ACCESS of a port 1 write at the top address
    bus.req1 = 1'b1; bus.write1 = 1'b1; bus.addr1 = 16'hFFFF; bus.wdata1 = 32'hA5A5A5A5;
    tick();
    check("ra_write_on", 64'({bus.mem_write, bus.mem_addr}), 64'({1'b1, 16'hFFFF}));
    reset = 1'b1;
    tick();
    check("ra_write_off", 64'(bus.mem_write), 64'(0));
    check("ra_nostatus", 64'({bus.ack1, bus.busy, bus.gnt_id}), 64'(0));
    reset = 1'b0;
    bus.req1 = 1'b0;
    busyCnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.busy || bus.ack1 || bus.mem_write) busyCnt++;
    end
    check("ra_stays_idle", 64'(busyCnt), 64'(0));

    // address 0x0000 is ordinary
    bdWrite(16'h0000, 32'h0BADF00D);
    issue(1'b1, 1'b0, 16'h0000, 32'h0, lat, wcyc);
    check("a0_rdata1", 64'(bus.rdata1), 64'h0BADF00D);
    check("a0_lat", 64'(lat), 64'(3));

    // 6: single transaction, req dropped on ack
    tick();
    issue(1'b0, 1'b1, 16'h0030, 32'hCAFEF00D, lat, wcyc);
    check("one_wr_cycles", 64'(wcyc), 64'(1));
    busyCnt = 0;
    writeCnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.busy) busyCnt++;
      if (bus.mem_write) writeCnt++;
    end
    check("one_no_busy", 64'(busyCnt), 64'(0));
    check("one_no_write", 64'(writeCnt), 64'(0));
    issue(1'b0, 1'b0, 16'h0030, 32'h0, lat, wcyc);
    check("one_readback", 64'(bus.rdata0), 64'hCAFEF00D);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
